// File: rtl/periph_fifo_target.sv
// Memory-mapped FIFO target on a core peripheral port (req/gnt request, r_valid response).
// Define PERIPH_FIFO_BLOCKING_EN to stall full pushes / empty pops instead of answering with an error.
module periph_fifo_target #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH/8,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] add_i,
   input  logic                  wen_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   output logic                  gnt_o,
   output logic                  r_valid_o,
   output logic [DATA_WIDTH-1:0] r_rdata_o,
   output logic                  r_opc_o,
   output logic                  not_empty_o,
   output logic                  full_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [7:0] OFF_DATA   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h01;
   localparam logic [7:0] OFF_CLEAR  = 8'h02;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;

   logic [7:0]            off;
   logic                  is_data, is_status, is_clear;
   logic                  is_empty, is_full;
   logic                  push_bad, pop_bad;
   logic                  accept, push;
   logic [DATA_WIDTH-1:0] status_word;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic                  opc_d;

   // Only the word offset add_i[9:2] is decoded; byte enables are ignored.
   logic unused_in;
   assign unused_in = ^{be_i, add_i[ADDR_WIDTH-1:10], add_i[1:0]};

   // Address decode, occupancy flags and grant
   always_comb begin
      off       = add_i[9:2];
      is_data   = (off == OFF_DATA);
      is_status = (off == OFF_STATUS);
      is_clear  = (off == OFF_CLEAR);
      is_empty  = (count_q == CW'(0));
      is_full   = (count_q == CW'(DEPTH));
      push_bad  = is_data & ~wen_i & is_full;
      pop_bad   = is_data & wen_i & is_empty;
`ifdef PERIPH_FIFO_BLOCKING_EN
      gnt_o     = req_i & ~(push_bad | pop_bad);
`else
      gnt_o     = req_i;
`endif
      accept    = req_i & gnt_o;

      status_word            = '0;
      status_word[CW-1:0]    = count_q;
      status_word[16]        = is_empty;
      status_word[17]        = is_full;
   end

   // Next FIFO state and response payload for the accepted access
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      push    = 1'b0;
      rdata_d = '0;
      opc_d   = 1'b0;
      if (accept) begin
         if (is_data) begin
            if (wen_i) begin
               if (pop_bad) begin
                  opc_d = 1'b1;
               end else begin
                  rdata_d = mem_q[head_q];
                  head_d  = head_q + PW'(1);
                  count_d = count_q - CW'(1);
               end
            end else begin
               if (push_bad) begin
                  opc_d = 1'b1;
               end else begin
                  push    = 1'b1;
                  tail_d  = tail_q + PW'(1);
                  count_d = count_q + CW'(1);
               end
            end
         end else if (is_status) begin
            if (wen_i) rdata_d = status_word;
         end else if (is_clear) begin
            if (!wen_i) begin
               head_d  = '0;
               tail_d  = '0;
               count_d = '0;
            end
         end else begin
            opc_d = 1'b1;
         end
      end
   end

   // Storage array carries no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         r_valid_o   <= 1'b0;
         r_rdata_o   <= '0;
         r_opc_o     <= 1'b0;
         not_empty_o <= 1'b0;
         full_o      <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         r_valid_o   <= accept;
         r_rdata_o   <= rdata_d;
         r_opc_o     <= opc_d;
         not_empty_o <= (count_d != CW'(0));
         full_o      <= (count_d == CW'(DEPTH));
      end
   end

endmodule
